// File: rtl/cpu_datapath_pkg.sv
//============================================================================
// Module      : cpu_datapath_pkg
// Description : Opcode and FSM state encodings shared by the datapath files.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package cpu_datapath_pkg;

    localparam int c_OP_W = 4;

    typedef enum logic [c_OP_W-1:0] {
        OP_LOAD = 4'd0,
        OP_MV   = 4'd1,
        OP_ADD  = 4'd2,
        OP_XOR  = 4'd3,
        OP_SUB  = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dp_alu.sv
//============================================================================
// Module      : dp_alu
// Description : Combinational ALU; SUB only when CPU_DATAPATH_SUB_EN is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dp_alu
    import cpu_datapath_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [c_OP_W-1:0] op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Bit DATA_W of the widened difference is the unsigned borrow.
    always_comb begin
        result = b;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = w_sum[DATA_W-1:0];
                carry  = w_sum[DATA_W];
            end
            OP_XOR: result = a ^ b;
`ifdef CPU_DATAPATH_SUB_EN
            OP_SUB: begin
                result = w_diff[DATA_W-1:0];
                carry  = w_diff[DATA_W];
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_datapath.sv
//============================================================================
// Module      : cpu_datapath
// Description : Multi-cycle register-file datapath (LOAD/MV/ADD/XOR, optional
//               SUB via CPU_DATAPATH_SUB_EN) with A/G staging registers.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [c_OP_W-1:0] instr_op,
    input  logic [IDX_W-1:0]  instr_rx,
    input  logic [IDX_W-1:0]  instr_ry,
    input  logic [DATA_W-1:0] instr_imm,
    output logic              done,
    output logic              err,
    output logic              carry,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e              r_state;
    state_e              w_next;
    logic [c_OP_W-1:0]   r_op;
    logic [IDX_W-1:0]    r_rx;
    logic [IDX_W-1:0]    r_ry;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_g;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_done;
    logic                r_err;
    logic                r_carry;

    logic                w_accept;
    logic                w_legal;
    logic                w_arith;
    logic                w_final;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_carry;

    assign w_accept = instr_valid & instr_ready;

    always_comb begin
        w_legal = 1'b0;
        w_arith = 1'b0;
        case (r_op)
            OP_LOAD, OP_MV: w_legal = 1'b1;
            OP_ADD, OP_XOR: begin
                w_legal = 1'b1;
                w_arith = 1'b1;
            end
`ifdef CPU_DATAPATH_SUB_EN
            OP_SUB: begin
                w_legal = 1'b1;
                w_arith = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = T1;
            T1:   w_next = w_arith ? T2 : IDLE;
            T2:   w_next = T3;
            T3:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Illegal opcodes finish in T1 like LOAD/MV but never write.
    always_comb begin
        instr_ready = (r_state == IDLE);
        w_final     = ((r_state == T1) && !w_arith) || (r_state == T3);
        w_wr_en     = 1'b0;
        w_wr_data   = r_g;
        if (r_state == T1 && w_legal && !w_arith) begin
            w_wr_en   = 1'b1;
            w_wr_data = (r_op == OP_LOAD) ? r_imm : r_regs[r_ry];
        end else if (r_state == T3) begin
            w_wr_en   = 1'b1;
        end
    end

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (r_a),
        .b      (r_regs[r_ry]),
        .op     (r_op),
        .result (w_alu_result),
        .carry  (w_alu_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_op    <= '0;
            r_rx    <= '0;
            r_ry    <= '0;
            r_imm   <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= instr_op;
                r_rx  <= instr_rx;
                r_ry  <= instr_ry;
                r_imm <= instr_imm;
            end
            if (r_state == T1 && w_arith) r_a <= r_regs[r_rx];
            if (r_state == T2) begin
                r_g     <= w_alu_result;
                r_carry <= w_alu_carry;
            end
            if (w_wr_en) r_regs[r_rx] <= w_wr_data;
            r_done <= w_final;
            r_err  <= w_final & ~w_legal;
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign carry    = r_carry;
    assign dbg_data = r_regs[dbg_addr];

endmodule

`default_nettype wire
